// File: rtl/key_step_counter_pkg.sv
// Shared constants for the key step counter: FSM encodings, default timing, step helper.
package key_step_counter_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_DELAY  = 2'd1;
  localparam logic [STATE_W-1:0] S_REPEAT = 2'd2;
  localparam logic [STATE_W-1:0] S_LOCK   = 2'd3;

  // 50 MHz defaults: 20 ms debounce, 0.5 s to first repeat, 0.1 s repeat period
  localparam int unsigned DEF_DEB_CYCLES = 1_000_000;
  localparam int unsigned DEF_REP_DELAY  = 25_000_000;
  localparam int unsigned DEF_REP_RATE   = 5_000_000;

  // Modulo-16 step in the requested direction
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v, input logic up);
    return up ? CNT_W'(v + 1'b1) : CNT_W'(v - 1'b1);
  endfunction

endpackage

// File: rtl/key_step_counter_debounce.sv
// Per-key 2-FF synchroniser and debouncer; reports the stable level and a one-cycle press pulse.
module key_step_counter_debounce
  import key_step_counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_raw,
  output logic key_lvl,
  output logic press
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [DW-1:0] dcnt;

  // Level flips only after DEB_CYCLES consecutive samples of the new synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      key_lvl <= 1'b1;
      dcnt    <= '0;
      press   <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n_raw};
      press <= 1'b0;
      if (sync[1] == key_lvl) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEB_CYCLES - 1)) begin
        key_lvl <= sync[1];
        dcnt    <= '0;
        press   <= ~sync[1];
      end else begin
        dcnt <= DW'(dcnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/key_step_counter.sv
// Two-button up/down stepper with auto-repeat producing a 4-bit value for the LED decoder.
module key_step_counter
  import key_step_counter_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned REP_DELAY  = DEF_REP_DELAY,
  parameter int unsigned REP_RATE   = DEF_REP_RATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  output logic [CNT_W-1:0] cnt,
  output logic             step,
  output logic             dir
);

  localparam int unsigned TMR_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);

  logic               up_lvl, up_press;
  logic               dn_lvl, dn_press;
  logic [STATE_W-1:0] state, state_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               step_d, dir_d;
  logic               held, other_press;

  key_step_counter_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n_raw (key_up_n),
    .key_lvl   (up_lvl),
    .press     (up_press)
  );

  key_step_counter_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n_raw (key_dn_n),
    .key_lvl   (dn_lvl),
    .press     (dn_press)
  );

  // dir always holds the key that started the current DELAY/REPEAT run
  assign held        = dir ? ~up_lvl : ~dn_lvl;
  assign other_press = dir ? dn_press : up_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      cnt   <= '0;
      step  <= 1'b0;
      dir   <= 1'b1;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
      cnt   <= cnt_d;
      step  <= step_d;
      dir   <= dir_d;
    end
  end

  always_comb begin
    state_d = state;
    tmr_d   = '0;
    cnt_d   = cnt;
    step_d  = 1'b0;
    dir_d   = dir;
    case (state)
      S_IDLE: begin
        if (up_press && dn_press) begin
          state_d = S_LOCK;
        end else if (up_press || dn_press) begin
          step_d  = 1'b1;
          dir_d   = up_press;
          cnt_d   = cnt_step(cnt, up_press);
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!held) begin
          state_d = S_IDLE;
        end else if (other_press) begin
          state_d = S_LOCK;
        end else if (tmr == TMR_W'(REP_DELAY - 1)) begin
          step_d  = 1'b1;
          cnt_d   = cnt_step(cnt, dir);
          state_d = S_REPEAT;
        end else begin
          tmr_d = TMR_W'(tmr + 1'b1);
        end
      end
      S_REPEAT: begin
        if (!held) begin
          state_d = S_IDLE;
        end else if (other_press) begin
          state_d = S_LOCK;
        end else if (tmr == TMR_W'(REP_RATE - 1)) begin
          step_d = 1'b1;
          cnt_d  = cnt_step(cnt, dir);
        end else begin
          tmr_d = TMR_W'(tmr + 1'b1);
        end
      end
      S_LOCK: begin
        if (up_lvl && dn_lvl) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_step_counter.sv
// Bench for key_step_counter: directed sequences, a segment table and a randomized run against a model.
module tb_key_step_counter;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic [3:0] cnt;
  logic       step;
  logic       dir;

  int total = 0;
  int bad   = 0;

  key_step_counter #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_up_n (key_up_n),
    .key_dn_n (key_dn_n),
    .cnt      (cnt),
    .step     (step),
    .dir      (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key index 0 = UP, 1 = DOWN. Stepping decided from "cycles since last step" rather than a timer.
  logic m_dl[2][2];
  logic m_lvl[2];
  logic m_prs[2];
  int   m_run[2];
  int   m_mode;        // 0 idle, 1 key active, 2 locked
  logic m_key;         // 1 = UP active
  logic m_first;
  int   m_since;
  int   m_cnt;
  logic m_step;
  logic m_dir;

  task automatic m_do_step(input logic up);
    m_cnt  = up ? (m_cnt + 1) % 16 : (m_cnt + 15) % 16;
    m_dir  = up;
    m_step = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_dl[k][0] = 1'b1; m_dl[k][1] = 1'b1;
          m_lvl[k] = 1'b1; m_prs[k] = 1'b0; m_run[k] = 0;
        end
        m_mode = 0; m_key = 1'b1; m_first = 1'b1; m_since = 0;
        m_cnt = 0; m_step = 1'b0; m_dir = 1'b1;
      end else begin
        m_step = 1'b0;
        case (m_mode)
          0: begin
            if (m_prs[0] && m_prs[1]) m_mode = 2;
            else if (m_prs[0] || m_prs[1]) begin
              m_do_step(m_prs[0]);
              m_key = m_prs[0]; m_mode = 1; m_first = 1'b1; m_since = 0;
            end
          end
          1: begin
            if (m_key ? m_lvl[0] : m_lvl[1]) m_mode = 0;
            else if (m_key ? m_prs[1] : m_prs[0]) m_mode = 2;
            else begin
              m_since++;
              if (m_since == (m_first ? RD : RR)) begin
                m_do_step(m_key);
                m_first = 1'b0; m_since = 0;
              end
            end
          end
          default: if (m_lvl[0] && m_lvl[1]) m_mode = 0;
        endcase
        for (int k = 0; k < 2; k++) begin
          logic d;
          d = m_dl[k][0];
          m_dl[k][0] = m_dl[k][1];
          m_dl[k][1] = (k == 0) ? key_up_n : key_dn_n;
          m_prs[k] = 1'b0;
          if (d == m_lvl[k]) m_run[k] = 0;
          else begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
              m_lvl[k] = d; m_run[k] = 0; m_prs[k] = ~d;
            end
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    key_up_n = 1'b1; key_dn_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 1);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n, output int steps);
    steps = 0;
    repeat (n) begin
      @(negedge clk);
      if (step === 1'b1) steps++;
    end
  endtask

  task automatic tap(input logic up, input int hold, input int rel);
    int s;
    if (up) key_up_n = 1'b0; else key_dn_n = 1'b0;
    run(hold, s);
    key_up_n = 1'b1; key_dn_n = 1'b1;
    run(rel, s);
  endtask

  typedef struct {
    logic       up_n;
    logic       dn_n;
    int         cycles;
    int         steps;
    logic [3:0] cnt;
    logic       dir;
  } vec_t;

  vec_t tbl[15];
  int   t3_t[4];
  int   t3_c[4];

  initial begin
    int n, first_at, idx, r, dur;

    tbl[0]  = '{1'b1, 1'b1, 10, 0, 4'd0,  1'b1};
    tbl[1]  = '{1'b1, 1'b0, 10, 1, 4'd15, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 12, 0, 4'd15, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10, 1, 4'd14, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 40, 0, 4'd14, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 12, 0, 4'd14, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 10, 1, 4'd15, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 12, 0, 4'd15, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 10, 1, 4'd0,  1'b1};
    tbl[9]  = '{1'b1, 1'b1, 12, 0, 4'd0,  1'b1};
    tbl[10] = '{1'b0, 1'b0, 40, 0, 4'd0,  1'b1};
    tbl[11] = '{1'b1, 1'b0, 30, 0, 4'd0,  1'b1};
    tbl[12] = '{1'b1, 1'b1, 12, 0, 4'd0,  1'b1};
    tbl[13] = '{1'b1, 1'b0, 10, 1, 4'd15, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 12, 0, 4'd15, 1'b0};
    t3_t = '{7, 27, 35, 43};
    t3_c = '{15, 0, 1, 2};

    // Single UP press: one step, 7 cycles after the press edge
    do_reset();
    key_up_n = 1'b0;
    n = 0; first_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin n++; if (first_at < 0) first_at = i; end
    end
    key_up_n = 1'b1;
    run(15, idx);
    check("t1_step_at", first_at, 7);
    check("t1_nsteps", n + idx, 1);
    check("t1_cnt", cnt, 1);
    check("t1_dir", dir, 1);

    // Bouncing UP never stabilises for DEB cycles
    do_reset();
    n = 0;
    repeat (10) begin
      key_up_n = 1'b0; run(3, idx); n += idx;
      key_up_n = 1'b1; run(1, idx); n += idx;
    end
    run(12, idx);
    check("t2_nsteps", n + idx, 0);
    check("t2_cnt", cnt, 0);

    // Hold UP from 14: first step, delayed repeat, then fast repeats with wrap
    do_reset();
    tap(1'b0, 10, 12);
    tap(1'b0, 10, 12);
    check("t3_start", cnt, 14);
    key_up_n = 1'b0;
    idx = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        if (idx < 4) begin
          check("t3_step_time", i, t3_t[idx]);
          check("t3_cnt", cnt, t3_c[idx]);
        end
        idx++;
      end
    end
    check("t3_nsteps", idx, 4);
    key_up_n = 1'b1;
    run(12, n);

    // Reset in the middle of REPEAT with UP still held
    do_reset();
    key_up_n = 1'b0;
    run(86, n);
    check("t5_cnt_before", cnt, 9);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_cnt", cnt, 0);
    check("t5_async_step", step, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idx = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        if (idx == 0) begin check("t5_first_at", i, 7);  check("t5_first_cnt", cnt, 1); end
        if (idx == 1) begin check("t5_rep_at", i, 27);   check("t5_rep_cnt", cnt, 2); end
        idx++;
      end
    end
    check("t5_nsteps", idx, 2);
    key_up_n = 1'b1;
    run(12, n);

    // Segment table: down wrap, key conflict lockout, simultaneous press
    do_reset();
    for (int v = 0; v < 15; v++) begin
      key_up_n = tbl[v].up_n;
      key_dn_n = tbl[v].dn_n;
      run(tbl[v].cycles, n);
      check($sformatf("tbl%0d_steps", v), n, tbl[v].steps);
      check($sformatf("tbl%0d_cnt", v), cnt, tbl[v].cnt);
      check($sformatf("tbl%0d_dir", v), dir, tbl[v].dir);
    end

    // Randomized key activity checked every cycle against the model
    do_reset();
    for (int s = 0; s < 120; s++) begin
      r = int'($urandom_range(0, 19));
      key_up_n = !(r < 7 || (r >= 14 && r < 16));
      key_dn_n = !(r >= 7 && r < 16);
      dur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 12));
      for (int c = 0; c < dur; c++) begin
        @(negedge clk);
        check("rand_cnt_step_dir", {cnt, step, dir}, {4'(m_cnt), m_step, m_dir});
        if ($urandom_range(0, 299) == 0) begin
          #2 rst_n = 1'b0;
          @(negedge clk);
          check("rand_reset", {cnt, step, dir}, {4'(m_cnt), m_step, m_dir});
          rst_n = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
